line_burst_responder: RTL

LINE_BURST_RESPONDER -- requirements
Module: line_burst_responder

---
 rtl/line_burst_responder_pkg.sv | 16 +
 rtl/line_burst_responder.sv | 103 ++++++++++
 2 files changed

// File: rtl/line_burst_responder_pkg.sv
// Shared cache-side types for the line burst responder: FSM states and
// beat bookkeeping constants used alongside the rv32i types.
package line_burst_responder_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } lbr_state_e;

  localparam int unsigned BEATS_PER_LINE = 4;
  localparam int unsigned BEAT_CNT_W     = 2;
  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS_PER_LINE - 1);

endpackage : line_burst_responder_pkg

// File: rtl/line_burst_responder.sv
// Converts cache line fill/writeback requests into fixed-length memory bursts,
// assembling or slicing the line one beat per accepted burst_resp.
module line_burst_responder
  import line_burst_responder_pkg::*;
#(
  parameter int unsigned s_offset = 5,
  parameter int unsigned s_line   = 256,
  parameter int unsigned s_beat   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pmem_read,
  input  logic              pmem_write,
  input  logic [31:0]       pmem_address,
  input  logic [s_line-1:0] pmem_wdata,
  output logic [s_line-1:0] pmem_rdata,
  output logic              pmem_resp,
  output logic              burst_read,
  output logic              burst_write,
  output logic [31:0]       burst_address,
  output logic [s_beat-1:0] burst_wdata,
  input  logic [s_beat-1:0] burst_rdata,
  input  logic              burst_resp
);

  lbr_state_e            state_q, state_d;
  logic [BEAT_CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [s_line-1:0]     wline_q, wline_d;
  logic [s_line-1:0]     rline_q, rline_d;
  logic [31:0]           aligned_addr;

  // Byte-offset bits are discarded by line alignment.
  logic unused_offset_bits;
  assign unused_offset_bits = ^pmem_address[s_offset-1:0];

  assign aligned_addr = {pmem_address[31:s_offset], {s_offset{1'b0}}};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wline_q <= '0;
      rline_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wline_q <= wline_d;
      rline_q <= rline_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wline_d = wline_q;
    rline_d = rline_q;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (pmem_read) begin
          addr_d  = aligned_addr;
          state_d = READ;
        end else if (pmem_write) begin
          addr_d  = aligned_addr;
          wline_d = pmem_wdata;
          state_d = WRITE;
        end
      end
      READ: begin
        if (burst_resp) begin
          rline_d[cnt_q*s_beat +: s_beat] = burst_rdata;
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      WRITE: begin
        if (burst_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pmem_resp     = (state_q == DONE);
  assign burst_read    = (state_q == READ);
  assign burst_write   = (state_q == WRITE);
  assign burst_address = addr_q;
  assign pmem_rdata    = rline_q;
  // Outgoing beat follows the counter combinationally; held at zero outside WRITE.
  assign burst_wdata   = (state_q == WRITE) ? wline_q[cnt_q*s_beat +: s_beat] : '0;

endmodule : line_burst_responder
